// File: rtl/pcs_tx_sequencer.sv
// TX-side 64b/66b PCS sequencer: init handshake, gearbox sequence, header phase and shared pause.
// Optional statistics counters are built when STATS_EN is defined.
module pcs_tx_sequencer #(
    parameter int DATA_WIDTH  = 32,
    parameter int INIT_CYCLES = 16,
    parameter int SEQ_MAX     = 32
) (
    input  logic        i_txc,
    input  logic        i_reset,
    input  logic        i_enable,
    output logic        o_init_done,
    output logic        o_tx_pause,
    output logic [5:0]  o_gearbox_seq,
    output logic        o_header_phase,
    output logic        o_mac_ready
`ifdef STATS_EN
    ,
    output logic [31:0] o_block_count,
    output logic [15:0] o_pause_count
`endif
);

    localparam bit WIDE = (DATA_WIDTH == 64);
    localparam int CW = (INIT_CYCLES < 2) ? 1 : $clog2(INIT_CYCLES);
    localparam logic [CW-1:0] INIT_LAST = CW'(INIT_CYCLES - 1);
    localparam logic [5:0] SEQ_LAST = 6'(SEQ_MAX);

    if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_width
        $error("pcs_tx_sequencer: DATA_WIDTH must be 32 or 64");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t          state_reg;
    state_t          state_next;
    logic [CW-1:0]   init_cnt_reg;
    logic [5:0]      seq_reg;
    logic            half_reg;
    logic            in_run;
    logic            pause_now;
    logic            seq_step;

    // In 32b mode a block spans two words, so seq only advances on the second half.
    assign seq_step = WIDE | half_reg;

    always_ff @(posedge i_txc or posedge i_reset) begin
        if (i_reset) begin
            state_reg    <= IDLE;
            init_cnt_reg <= '0;
            seq_reg      <= '0;
            half_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;

            if (state_reg == INIT && state_next == INIT) begin
                init_cnt_reg <= init_cnt_reg + 1'b1;
            end else begin
                init_cnt_reg <= '0;
            end

            if (state_reg == RUN && state_next == RUN) begin
                half_reg <= WIDE ? 1'b0 : ~half_reg;
                if (seq_step) begin
                    seq_reg <= (seq_reg == SEQ_LAST) ? 6'd0 : seq_reg + 6'd1;
                end
            end else begin
                seq_reg  <= '0;
                half_reg <= 1'b0;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (i_enable) begin
                    state_next = INIT;
                end
            end
            INIT: begin
                if (!i_enable) begin
                    state_next = IDLE;
                end else if (init_cnt_reg == INIT_LAST) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (!i_enable) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs decode flops only, so i_enable never reaches them combinationally.
    always_comb begin
        in_run         = (state_reg == RUN);
        pause_now      = in_run && (seq_reg == SEQ_LAST);
        o_init_done    = in_run;
        o_tx_pause     = pause_now;
        o_gearbox_seq  = seq_reg;
        o_header_phase = in_run && (WIDE || !half_reg);
        o_mac_ready    = in_run && !pause_now;
    end

`ifdef STATS_EN
    logic        block_end;
    logic [31:0] block_count_reg;
    logic [15:0] pause_count_reg;

    assign block_end = in_run && !pause_now && seq_step;

    always_ff @(posedge i_txc or posedge i_reset) begin
        if (i_reset) begin
            block_count_reg <= '0;
            pause_count_reg <= '0;
        end else if (state_next != RUN) begin
            block_count_reg <= '0;
            pause_count_reg <= '0;
        end else begin
            if (block_end && block_count_reg != '1) begin
                block_count_reg <= block_count_reg + 32'd1;
            end
            if (pause_now && pause_count_reg != '1) begin
                pause_count_reg <= pause_count_reg + 16'd1;
            end
        end
    end

    assign o_block_count = block_count_reg;
    assign o_pause_count = pause_count_reg;
`endif

endmodule

// File: tb/tb_pcs_tx_sequencer.sv
// Self-checking bench for pcs_tx_sequencer: 64b and 32b instances share clock, reset and enable.
module tb_pcs_tx_sequencer;

    logic clk;
    logic rst;
    logic en;

    logic       o64_init_done, o64_tx_pause, o64_header_phase, o64_mac_ready;
    logic [5:0] o64_gearbox_seq;
    logic       o32_init_done, o32_tx_pause, o32_header_phase, o32_mac_ready;
    logic [5:0] o32_gearbox_seq;
`ifdef STATS_EN
    logic [31:0] o64_block_count, o32_block_count;
    logic [15:0] o64_pause_count, o32_pause_count;
`endif

    int checks = 0;
    int failures = 0;

    pcs_tx_sequencer #(.DATA_WIDTH(64), .INIT_CYCLES(16), .SEQ_MAX(32)) u64 (
        .i_txc(clk), .i_reset(rst), .i_enable(en),
        .o_init_done(o64_init_done), .o_tx_pause(o64_tx_pause),
        .o_gearbox_seq(o64_gearbox_seq), .o_header_phase(o64_header_phase),
        .o_mac_ready(o64_mac_ready)
`ifdef STATS_EN
        , .o_block_count(o64_block_count), .o_pause_count(o64_pause_count)
`endif
    );

    pcs_tx_sequencer #(.DATA_WIDTH(32), .INIT_CYCLES(16), .SEQ_MAX(32)) u32 (
        .i_txc(clk), .i_reset(rst), .i_enable(en),
        .o_init_done(o32_init_done), .o_tx_pause(o32_tx_pause),
        .o_gearbox_seq(o32_gearbox_seq), .o_header_phase(o32_header_phase),
        .o_mac_ready(o32_mac_ready)
`ifdef STATS_EN
        , .o_block_count(o32_block_count), .o_pause_count(o32_pause_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Model: count consecutive edges with enable high; RUN once 17 have been seen.
    int streak;
    always @(posedge clk or posedge rst) begin
        if (rst) streak <= 0;
        else if (en) streak <= streak + 1;
        else streak <= 0;
    end

    task automatic model(input int dw, input int s,
                         output logic done, output logic pause, output logic hdr,
                         output logic ready, output logic [5:0] seq,
                         output int blocks, output int pauses);
        int k;
        int p;
        done = 0; pause = 0; hdr = 0; ready = 0; seq = 0; blocks = 0; pauses = 0;
        if (s >= 17) begin
            k = s - 17;
            done = 1;
            if (dw == 64) begin
                seq    = 6'(k % 33);
                hdr    = 1;
                pauses = k / 33;
                blocks = k - k / 33;
            end else begin
                p      = k % 66;
                seq    = 6'(p / 2);
                hdr    = (p % 2 == 0);
                pauses = 2 * (k / 66) + ((p > 64) ? p - 64 : 0);
                blocks = k / 2 - k / 66;
            end
            pause = (seq == 6'd32);
            ready = !pause;
        end
    endtask

    always @(negedge clk) begin
        logic d, pz, h, r;
        logic [5:0] sq;
        int b, pc;
        model(64, streak, d, pz, h, r, sq, b, pc);
        check("cmp64_init_done", o64_init_done, d);
        check("cmp64_tx_pause", o64_tx_pause, pz);
        check("cmp64_header", o64_header_phase, h);
        check("cmp64_mac_ready", o64_mac_ready, r);
        check("cmp64_seq", o64_gearbox_seq, sq);
`ifdef STATS_EN
        check("cmp64_blocks", o64_block_count, b);
        check("cmp64_pauses", o64_pause_count, pc);
`endif
        model(32, streak, d, pz, h, r, sq, b, pc);
        check("cmp32_init_done", o32_init_done, d);
        check("cmp32_tx_pause", o32_tx_pause, pz);
        check("cmp32_header", o32_header_phase, h);
        check("cmp32_mac_ready", o32_mac_ready, r);
        check("cmp32_seq", o32_gearbox_seq, sq);
`ifdef STATS_EN
        check("cmp32_blocks", o32_block_count, b);
        check("cmp32_pauses", o32_pause_count, pc);
`endif
    end

    task automatic wait_init(input string name);
        int n;
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (o64_init_done) begin
                n = i;
                break;
            end
        end
        check(name, n, 17);
    endtask

    initial begin
        int first64, second64, p32, nr32, idx32;
        rst = 1'b1;
        en  = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        check("reset_init_done64", o64_init_done, 0);
        check("reset_seq32", o32_gearbox_seq, 0);
        check("reset_header32", o32_header_phase, 0);

        en = 1'b1;
        wait_init("init_latency");
        $display("txn enable: RUN entered");
        check("first_seq64", o64_gearbox_seq, 0);
        check("first_header32", o32_header_phase, 1);
        check("first_pause32", o32_tx_pause, 0);
        check("first_done32", o32_init_done, 1);

        first64 = -1; second64 = -1; p32 = 0; nr32 = 0; idx32 = 0;
        for (int k = 0; k < 330; k++) begin
            if (o64_tx_pause) begin
                if (first64 < 0) first64 = k;
                else if (second64 < 0) second64 = k;
            end
            if (k < 132) begin
                if (o32_tx_pause) begin
                    p32++;
                    idx32 += k;
                end
                if (!o32_mac_ready) nr32++;
            end
            @(posedge clk); #1;
        end
        $display("txn run330: first64=%0d second64=%0d pauses32=%0d", first64, second64, p32);
        check("first_pause64", first64, 32);
        check("second_pause64", second64, 65);
        check("pause_count32_132", p32, 4);
        check("pause_index_sum32", idx32, 390);
        check("mac_ready_low32", nr32, 4);
`ifdef STATS_EN
        check("stats_blocks64_330", o64_block_count, 320);
        check("stats_pauses64_330", o64_pause_count, 10);
`endif

        repeat (64) @(posedge clk);
        #1;
        check("midpause_pause32", o32_tx_pause, 1);
        check("midpause_seq32", o32_gearbox_seq, 32);
        en = 1'b0;
        @(posedge clk); #1;
        $display("txn drop enable mid-pause");
        check("drop_done32", o32_init_done, 0);
        check("drop_pause32", o32_tx_pause, 0);
        check("drop_seq32", o32_gearbox_seq, 0);
`ifdef STATS_EN
        check("drop_blocks64", o64_block_count, 0);
        check("drop_pauses32", o32_pause_count, 0);
`endif
        en = 1'b1;
        wait_init("reenable_latency");
        $display("txn re-enable: RUN entered");

        repeat (5) @(posedge clk);
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        $display("txn async reset mid-RUN");
        check("async_done64", o64_init_done, 0);
        check("async_seq64", o64_gearbox_seq, 0);
        check("async_header32", o32_header_phase, 0);
        check("async_ready32", o32_mac_ready, 0);
        en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("post_reset_idle64", o64_init_done, 0);

        en = 1'b1;
        repeat (11) @(posedge clk);
        #1 en = 1'b0;
        @(posedge clk); #1;
        check("pulse_done32", o32_init_done, 0);
        en = 1'b1;
        wait_init("pulse_restart_latency");
        $display("txn enable pulse during INIT: full count repeated");

        repeat (40) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
